// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: parametrised single-clock FIFO with an occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a selectable read mode (registered read or first-word-fall-through).
//
// Ports:
//   clk          rising-edge clock for all logic
//   reset        synchronous, active-high; clears pointers, count and flags
//   write_en     write request; accepted when not full or when a read is accepted
//   read_en      read request (FWFT: pop the head word); accepted when not empty
//   data_in      write data
//   clear_err    clears the sticky overflow/underflow flags
//   data_out     read data (FWFT=0: registered; FWFT=1: current head word)
//   data_valid   FWFT=0: one cycle after an accepted read; FWFT=1: !empty
//   empty, full, almost_empty, almost_full   registered status flags
//   count        current occupancy 0..DEPTH
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
module fifo_sync_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int PTR_SIZE      = 5,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [PTR_SIZE-1:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_SIZE-1:0]   wr_ptr;
  logic [PTR_SIZE-1:0]   rd_ptr;
  logic [PTR_SIZE-1:0]   wr_ptr_next;
  logic [PTR_SIZE-1:0]   rd_ptr_next;
  logic [PTR_SIZE-1:0]   count_next;
  logic                  rd_ok;
  logic                  wr_ok;

  // Request acceptance and next-state pointers/occupancy.
  always_comb begin
    rd_ok       = read_en && !empty;
    // A full FIFO can still take a write when a read frees a slot this cycle.
    wr_ok       = write_en && (!full || rd_ok);
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_ok) begin
      wr_ptr_next = wr_ptr + PTR_SIZE'(1);
    end else begin
      wr_ptr_next = wr_ptr;
    end
    if (rd_ok) begin
      rd_ptr_next = rd_ptr + PTR_SIZE'(1);
    end else begin
      rd_ptr_next = rd_ptr;
    end
    // The extra wrap bit makes the pointer difference the exact occupancy 0..DEPTH.
    count_next = wr_ptr_next - rd_ptr_next;
  end

  // Pointers, occupancy, status flags (from next-state count) and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= {PTR_SIZE{1'b0}};
      rd_ptr       <= {PTR_SIZE{1'b0}};
      count        <= {PTR_SIZE{1'b0}};
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      empty        <= (count_next == PTR_SIZE'(0));
      full         <= (count_next == PTR_SIZE'(DEPTH));
      almost_empty <= (count_next <= PTR_SIZE'(AEMPTY_THRESH));
      almost_full  <= (count_next >= PTR_SIZE'(AFULL_THRESH));
      // Set has priority over clear so an error in the clearing cycle is not lost.
      if (write_en && !wr_ok) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
      if (read_en && !rd_ok) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end else begin
        underflow <= underflow;
      end
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) begin
      mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      // Registered read port: data_out updates only on an accepted read.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_out   <= {DATA_WIDTH{1'b0}};
          data_valid <= 1'b0;
        end else begin
          data_valid <= rd_ok;
          if (rd_ok) begin
            data_out <= mem[rd_ptr[ADDR_W-1:0]];
          end else begin
            data_out <= data_out;
          end
        end
      end
    end else begin : g_fwft
      // Head word is always presented; it is meaningful whenever not empty.
      assign data_out   = mem[rd_ptr[ADDR_W-1:0]];
      assign data_valid = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Self-checking bench for fifo_sync_flex: one standard-mode instance (dut0) and
// one FWFT instance (dut1), directed scenario tasks followed by randomized
// traffic checked against a queue-based reference model.
module tb_fifo_sync_flex;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       we0 = 1'b0, re0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic [7:0] dout0;
  logic       dv0, empty0, full0, ae0, af0, ovf0, udf0;
  logic [4:0] cnt0;

  logic       we1 = 1'b0, re1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic [7:0] dout1;
  logic       dv1, empty1, full1, ae1, af1, ovf1, udf1;
  logic [4:0] cnt1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_dout0 = 8'h00;
  bit         m_dv0 = 1'b0;
  bit         m_ovf0 = 1'b0, m_udf0 = 1'b0, m_ovf1 = 1'b0, m_udf1 = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(16), .PTR_SIZE(5), .AFULL_THRESH(14),
                   .AEMPTY_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .write_en(we0), .read_en(re0), .data_in(din0),
    .clear_err(clr0), .data_out(dout0), .data_valid(dv0), .empty(empty0),
    .full(full0), .almost_empty(ae0), .almost_full(af0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0));

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(16), .PTR_SIZE(5), .AFULL_THRESH(14),
                   .AEMPTY_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .write_en(we1), .read_en(re1), .data_in(din1),
    .clear_err(clr1), .data_out(dout1), .data_valid(dv1), .empty(empty1),
    .full(full1), .almost_empty(ae1), .almost_full(af1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1));

  // Expected {count, empty, full, almost_empty, almost_full, overflow, underflow}
  function automatic logic [10:0] exp_stat(int s, bit o, bit u);
    return {5'(s), (s == 0), (s == 16), (s <= 2), (s >= 14), o, u};
  endfunction

  // One clock edge: update the models from the inputs seen at the edge, then
  // step 1 time unit past the edge so outputs are sampled away from it.
  task automatic tick();
    bit rd, wr;
    @(posedge clk);
    if (reset) begin
      q0.delete(); q1.delete();
      m_dout0 = 8'h00; m_dv0 = 1'b0;
      m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;
    end else begin
      rd = re0 && (q0.size() > 0);
      wr = we0 && ((q0.size() < 16) || rd);
      m_dv0 = rd;
      if (rd) m_dout0 = q0.pop_front();
      if (wr) q0.push_back(din0);
      if (we0 && !wr) m_ovf0 = 1'b1; else if (clr0) m_ovf0 = 1'b0;
      if (re0 && !rd) m_udf0 = 1'b1; else if (clr0) m_udf0 = 1'b0;

      rd = re1 && (q1.size() > 0);
      wr = we1 && ((q1.size() < 16) || rd);
      if (rd) void'(q1.pop_front());
      if (wr) q1.push_back(din1);
      if (we1 && !wr) m_ovf1 = 1'b1; else if (clr1) m_ovf1 = 1'b0;
      if (re1 && !rd) m_udf1 = 1'b1; else if (clr1) m_udf1 = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total_cnt++;
    if ({cnt0, empty0, full0, ae0, af0, ovf0, udf0} !== 11'b00000_1_0_1_0_0_0) begin
      $display("FAIL reset_status0 got %b want %b", {cnt0, empty0, full0, ae0, af0, ovf0, udf0}, 11'b00000_1_0_1_0_0_0);
    end else pass_cnt++;
    total_cnt++;
    if ({dv0, dout0} !== 9'h000) begin
      $display("FAIL reset_data0 got %h want %h", {dv0, dout0}, 9'h000);
    end else pass_cnt++;
    total_cnt++;
    if ({cnt1, empty1, full1, ae1, af1, ovf1, udf1, dv1} !== 12'b00000_1_0_1_0_0_0_0) begin
      $display("FAIL reset_status1 got %b want %b", {cnt1, empty1, full1, ae1, af1, ovf1, udf1, dv1}, 12'b00000_1_0_1_0_0_0_0);
    end else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; din0 = 8'(i);
      tick();
      total_cnt++;
      if ({cnt0, empty0, full0, ae0, af0, ovf0, udf0} !== exp_stat(i + 1, 1'b0, 1'b0)) begin
        $display("FAIL fill_status[%0d] got %b want %b", i, {cnt0, empty0, full0, ae0, af0, ovf0, udf0}, exp_stat(i + 1, 1'b0, 1'b0));
      end else pass_cnt++;
    end
    we0 = 1'b0;
  endtask

  task automatic test_overflow_drain();
    we0 = 1'b1; din0 = 8'hFF;
    tick();
    we0 = 1'b0;
    total_cnt++;
    if ({cnt0, empty0, full0, ae0, af0, ovf0, udf0} !== exp_stat(16, 1'b1, 1'b0)) begin
      $display("FAIL overflow_status got %b want %b", {cnt0, empty0, full0, ae0, af0, ovf0, udf0}, exp_stat(16, 1'b1, 1'b0));
    end else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      re0 = 1'b1;
      tick();
      total_cnt++;
      if ({dv0, dout0, cnt0, empty0} !== {1'b1, 8'(i), 5'(15 - i), (i == 15)}) begin
        $display("FAIL drain[%0d] got dv/data/cnt/empty %h want %h", i, {dv0, dout0, cnt0, empty0}, {1'b1, 8'(i), 5'(15 - i), (i == 15)});
      end else pass_cnt++;
    end
    re0 = 1'b0;
    tick();
    total_cnt++;
    if ({dv0, dout0} !== {1'b0, 8'h0F}) begin
      $display("FAIL idle_after_drain got %h want %h", {dv0, dout0}, {1'b0, 8'h0F});
    end else pass_cnt++;
  endtask

  task automatic test_underflow();
    re0 = 1'b1;
    tick();
    re0 = 1'b0;
    total_cnt++;
    if ({cnt0, empty0, full0, ae0, af0, ovf0, udf0, dv0, dout0} !== {exp_stat(0, 1'b1, 1'b1), 1'b0, 8'h0F}) begin
      $display("FAIL underflow got %h want %h", {cnt0, empty0, full0, ae0, af0, ovf0, udf0, dv0, dout0}, {exp_stat(0, 1'b1, 1'b1), 1'b0, 8'h0F});
    end else pass_cnt++;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    total_cnt++;
    if ({cnt0, empty0, full0, ae0, af0, ovf0, udf0} !== exp_stat(0, 1'b0, 1'b0)) begin
      $display("FAIL clear_err got %b want %b", {cnt0, empty0, full0, ae0, af0, ovf0, udf0}, exp_stat(0, 1'b0, 1'b0));
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; din0 = 8'(i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      we0 = 1'b1; re0 = 1'b1; din0 = 8'hA0 + 8'(i);
      tick();
      total_cnt++;
      if ({cnt0, full0, ovf0, dv0, dout0} !== {5'd16, 1'b1, 1'b0, 1'b1, 8'(i)}) begin
        $display("FAIL simul_rw[%0d] got %h want %h", i, {cnt0, full0, ovf0, dv0, dout0}, {5'd16, 1'b1, 1'b0, 1'b1, 8'(i)});
      end else pass_cnt++;
    end
    we0 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      re0 = 1'b1;
      want = (j < 12) ? 8'(j + 4) : 8'hA0 + 8'(j - 12);
      tick();
      total_cnt++;
      if ({dv0, dout0} !== {1'b1, want}) begin
        $display("FAIL wrap_drain[%0d] got %h want %h", j, {dv0, dout0}, {1'b1, want});
      end else pass_cnt++;
    end
    re0 = 1'b0;
    tick();
  endtask

  task automatic test_fwft();
    we1 = 1'b1; din1 = 8'h5A;
    tick();
    we1 = 1'b0;
    total_cnt++;
    if ({dout1, dv1, empty1, cnt1} !== {8'h5A, 1'b1, 1'b0, 5'd1}) begin
      $display("FAIL fwft_head got %h want %h", {dout1, dv1, empty1, cnt1}, {8'h5A, 1'b1, 1'b0, 5'd1});
    end else pass_cnt++;
    re1 = 1'b1;
    tick();
    re1 = 1'b0;
    total_cnt++;
    if ({empty1, dv1, cnt1, udf1} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      $display("FAIL fwft_pop got %b want %b", {empty1, dv1, cnt1, udf1}, {1'b1, 1'b0, 5'd0, 1'b0});
    end else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 8; i++) begin
      we0 = 1'b1; din0 = 8'h10 + 8'(i);
      tick();
    end
    re0 = 1'b1;
    tick();
    re0 = 1'b0;
    reset = 1'b1; we0 = 1'b1; din0 = 8'hEE;
    tick();
    reset = 1'b0; we0 = 1'b0;
    total_cnt++;
    if ({cnt0, empty0, full0, ae0, af0, ovf0, udf0, dv0, dout0} !== {exp_stat(0, 1'b0, 1'b0), 1'b0, 8'h00}) begin
      $display("FAIL midstream_reset got %h want %h", {cnt0, empty0, full0, ae0, af0, ovf0, udf0, dv0, dout0}, {exp_stat(0, 1'b0, 1'b0), 1'b0, 8'h00});
    end else pass_cnt++;
    we0 = 1'b1; din0 = 8'h33;
    tick();
    we0 = 1'b0; re0 = 1'b1;
    tick();
    re0 = 1'b0;
    total_cnt++;
    if ({dv0, dout0, empty0} !== {1'b1, 8'h33, 1'b1}) begin
      $display("FAIL post_reset_rw got %h want %h", {dv0, dout0, empty0}, {1'b1, 8'h33, 1'b1});
    end else pass_cnt++;
  endtask

  task automatic test_random();
    int pw, pr;
    for (int c = 0; c < 600; c++) begin
      // Alternate write-heavy and read-heavy phases to visit full and empty.
      if (((c / 60) % 2) == 0) begin pw = 80; pr = 35; end
      else begin pw = 35; pr = 80; end
      we0 = ($urandom_range(99, 0) < pw); re0 = ($urandom_range(99, 0) < pr);
      we1 = ($urandom_range(99, 0) < pw); re1 = ($urandom_range(99, 0) < pr);
      din0 = 8'($urandom); din1 = 8'($urandom);
      clr0 = ($urandom_range(99, 0) < 4); clr1 = ($urandom_range(99, 0) < 4);
      tick();
      total_cnt++;
      if ({cnt0, empty0, full0, ae0, af0, ovf0, udf0} !== exp_stat(q0.size(), m_ovf0, m_udf0)) begin
        $display("FAIL rand_status0[%0d] got %b want %b", c, {cnt0, empty0, full0, ae0, af0, ovf0, udf0}, exp_stat(q0.size(), m_ovf0, m_udf0));
      end else pass_cnt++;
      total_cnt++;
      if ({dv0, dout0} !== {m_dv0, m_dout0}) begin
        $display("FAIL rand_data0[%0d] got %h want %h", c, {dv0, dout0}, {m_dv0, m_dout0});
      end else pass_cnt++;
      total_cnt++;
      if ({cnt1, empty1, full1, ae1, af1, ovf1, udf1} !== exp_stat(q1.size(), m_ovf1, m_udf1)) begin
        $display("FAIL rand_status1[%0d] got %b want %b", c, {cnt1, empty1, full1, ae1, af1, ovf1, udf1}, exp_stat(q1.size(), m_ovf1, m_udf1));
      end else pass_cnt++;
      if (q1.size() > 0) begin
        total_cnt++;
        if ({dv1, dout1} !== {1'b1, q1[0]}) begin
          $display("FAIL rand_head1[%0d] got %h want %h", c, {dv1, dout1}, {1'b1, q1[0]});
        end else pass_cnt++;
      end else begin
        total_cnt++;
        if (dv1 !== 1'b0) begin
          $display("FAIL rand_valid1[%0d] got %b want %b", c, dv1, 1'b0);
        end else pass_cnt++;
      end
    end
    we0 = 1'b0; re0 = 1'b0; clr0 = 1'b0;
    we1 = 1'b0; re1 = 1'b0; clr1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
Parametrised synchronous FIFO, successor to the basic 16x8 FIFO. Adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Adds a selectable output mode: registered read (standard) or first-word-fall-through (FWFT). Used as the general-purpose single-clock buffer between producer/consumer stages.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out.
DEPTH, 16, number of entries; must be a power of 2, at least 2.
PTR_SIZE, 5, pointer/count width = log2(DEPTH)+1 (extra wrap bit).
AFULL_THRESH, 14, almost_full asserted when count >= this value (1..DEPTH).
AEMPTY_THRESH, 2, almost_empty asserted when count <= this value (0..DEPTH-1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
write_en  in  1  write request.
read_en  in  1  read request (FWFT: pop the head word).
data_in  in  DATA_WIDTH  write data.
clear_err  in  1  clears overflow/underflow sticky flags.
data_out  out  DATA_WIDTH  read data.
data_valid  out  1  data_out holds a valid word (see Behaviour).
empty  out  1  count == 0.
full  out  1  count == DEPTH.
almost_empty  out  1  count <= AEMPTY_THRESH.
almost_full  out  1  count >= AFULL_THRESH.
count  out  PTR_SIZE  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was rejected.
underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (reset=1 at a clk edge): wr_ptr=rd_ptr=0, count=0, data_out=0, data_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not cleared. Reset has priority over all other inputs, including mid-stream traffic; all stored data is discarded.
- Read accepted (rd_ok) = read_en && !empty.
- Write accepted (wr_ok) = write_en && (!full || rd_ok).
  - Full with both requests: both accepted, count unchanged, no overflow.
  - Empty with both requests: write accepted, read rejected, underflow set.
- Pointers: PTR_SIZE bits. Memory is indexed by the low log2(DEPTH) bits, so addresses wrap naturally. Pointers advance by 1 on wr_ok/rd_ok respectively.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. All status flags are registered and derived from the next-state count, so they are valid in the same cycle as count.
- overflow: set on write_en && !wr_ok. underflow: set on read_en && !rd_ok. Both hold until clear_err or reset. If set and clear in the same cycle, set wins.
- FWFT=0 (standard mode):
  - On rd_ok, data_out <= mem[rd_ptr] at that edge; data_valid=1 for that one following cycle, else 0.
  - data_out holds its last value when there is no read. Read latency is 1 clock.
- FWFT=1 (first-word-fall-through):
  - data_out = mem[rd_ptr] continuously; data_valid = !empty.
  - A word written into an empty FIFO appears on data_out in the cycle after the write edge.
  - read_en pops the head; the next word (if any) appears after that edge.
  - data_out content is don't-care while empty.
- Rejected writes never alter memory or pointers. Rejected reads never alter data_out in standard mode.
- Throughput: one write and one read per cycle, sustained.

Test Plan:
- Reset, then write 0x00..0x0F on 16 consecutive cycles. Required: count steps 1..16; almost_empty falls when count=3; almost_full rises when count=14; full=1 at count=16; overflow=0.
- While full, write 0xFF. Required: overflow=1, count stays 16. Then read 16 words. Required (FWFT=0): data_out=0x00..0x0F, each with data_valid one cycle after its read_en; empty=1 at end.
- While empty, assert read_en. Required: underflow=1, count=0, data_out unchanged. Pulse clear_err. Required: underflow=0 next cycle.
- Full FIFO, write_en=read_en=1 for 4 cycles with data 0xA0..0xA3. Required: count stays 16, no overflow, first reads return 0x00..0x03. Then drain. Required: 0x04..0x0F followed by 0xA0..0xA3, confirming pointer wrap-around.
- FWFT=1 instance: write 0x5A into empty. Required: the next cycle shows data_out=0x5A, data_valid=1, empty=0. Then read_en once. Required: empty=1, data_valid=0.
- Write 8 words, assert reset mid-stream with write_en=1. Required: next cycle count=0, empty=1, all flags at reset values, data_out=0. Subsequent write/read of 0x33 returns 0x33.
